// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 matrix keypad scanner.
// Holds the scanner state encoding, the named key codes for the
// letter/symbol keys, and the row/column to key-code map.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    localparam logic [3:0] KEY_ADD  = 4'd10;
    localparam logic [3:0] KEY_SUB  = 4'd11;
    localparam logic [3:0] KEY_C    = 4'd12;
    localparam logic [3:0] KEY_D    = 4'd13;
    localparam logic [3:0] KEY_STAR = 4'd14;
    localparam logic [3:0] KEY_HASH = 4'd15;

    // Indexed [row][column]; row 0 is the top row of the keypad.
    localparam logic [3:0] KEY_MAP [4][4] = '{
        '{4'd1,     4'd2, 4'd3,     KEY_ADD},
        '{4'd4,     4'd5, 4'd6,     KEY_SUB},
        '{4'd7,     4'd8, 4'd9,     KEY_C},
        '{KEY_STAR, 4'd0, KEY_HASH, KEY_D}
    };

    function automatic logic [3:0] key_code(input logic [1:0] row, input logic [1:0] col);
        return KEY_MAP[row][col];
    endfunction

endpackage

// File: rtl/row_sync.sv
// Two-flop synchronizer for the raw keypad rows.
// Resets to all-high so an idle keypad is seen during and after reset.
module row_sync (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] rows_in,
    output logic [3:0] rows_s
);

    logic [3:0] meta_q, meta_d;
    logic [3:0] sync_q, sync_d;

    // Next values simply shift the raw rows one stage down the chain.
    always_comb begin
        meta_d = rows_in;
        sync_d = meta_q;
    end

    // Synchronizer flops, cleared to the idle (all-high) pattern on reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            meta_q <= 4'hF;
            sync_q <= 4'hF;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign rows_s = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with debounce for the calculator control unit.
// Walks the columns, latches a single pressed key, debounces press and
// release, and raises trig (plus a one-cycle key_strobe) while it is held.
// Optional macro KEYPAD_MULTI_ERR_EN adds a multi_key pulse output that
// flags scan samples with more than one row low.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV     = 50000,
    parameter int DEBOUNCE_CNT = 250000,
    parameter int CNT_W        = 32
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] row_n,
    output logic [3:0] col_n,
    output logic [3:0] keyPressed,
    output logic       trig,
`ifdef KEYPAD_MULTI_ERR_EN
    output logic       multi_key,
`endif
    output logic       key_strobe
);

    localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CNT - 1);

    logic [3:0]       rows_s;
    state_t           state_q, state_d;
    logic [1:0]       col_idx_q, col_idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       row_idx_q, row_idx_d;
    logic [3:0]       row_pat_q, row_pat_d;
    logic [3:0]       key_q, key_d;
    logic             trig_q, trig_d;
    logic             strobe_q, strobe_d;
    logic             one_low;
    logic [1:0]       low_idx;
    logic             latched_low;

    row_sync u_row_sync (
        .clock   (clock),
        .reset   (reset),
        .rows_in (row_n),
        .rows_s  (rows_s)
    );

    // Classify the synchronized rows: exactly one low row and which one it is.
    always_comb begin
        one_low = 1'b1;
        low_idx = 2'd0;
        case (rows_s)
            4'b1110: low_idx = 2'd0;
            4'b1101: low_idx = 2'd1;
            4'b1011: low_idx = 2'd2;
            4'b0111: low_idx = 2'd3;
            default: one_low = 1'b0;
        endcase
    end

    assign latched_low = ~rows_s[row_idx_q];

    // Scan / debounce / held / release sequencing and output updates.
    always_comb begin
        state_d   = state_q;
        col_idx_d = col_idx_q;
        cnt_d     = cnt_q;
        row_idx_d = row_idx_q;
        row_pat_d = row_pat_q;
        key_d     = key_q;
        trig_d    = trig_q;
        strobe_d  = 1'b0;
        case (state_q)
            SCAN: begin
                if (cnt_q == SCAN_LAST) begin
                    cnt_d = '0;
                    if (one_low) begin
                        row_idx_d = low_idx;
                        row_pat_d = rows_s;
                        state_d   = DEBOUNCE;
                    end else begin
                        col_idx_d = col_idx_q + 2'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DEBOUNCE: begin
                if (rows_s == row_pat_q) begin
                    if (cnt_q == DEB_LAST) begin
                        cnt_d    = '0;
                        key_d    = key_code(row_idx_q, col_idx_q);
                        trig_d   = 1'b1;
                        strobe_d = 1'b1;
                        state_d  = HELD;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else begin
                    cnt_d   = '0;
                    state_d = SCAN;
                end
            end
            HELD: begin
                if (!latched_low) begin
                    cnt_d   = '0;
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                if (latched_low) begin
                    cnt_d   = '0;
                    state_d = HELD;
                end else if (cnt_q == DEB_LAST) begin
                    cnt_d     = '0;
                    trig_d    = 1'b0;
                    col_idx_d = col_idx_q + 2'd1;
                    state_d   = SCAN;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d   = SCAN;
                col_idx_d = 2'd0;
                cnt_d     = '0;
                key_d     = 4'd0;
                trig_d    = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= SCAN;
            col_idx_q <= 2'd0;
            cnt_q     <= '0;
            row_idx_q <= 2'd0;
            row_pat_q <= 4'hF;
            key_q     <= 4'd0;
            trig_q    <= 1'b0;
            strobe_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            col_idx_q <= col_idx_d;
            cnt_q     <= cnt_d;
            row_idx_q <= row_idx_d;
            row_pat_q <= row_pat_d;
            key_q     <= key_d;
            trig_q    <= trig_d;
            strobe_q  <= strobe_d;
        end
    end

`ifdef KEYPAD_MULTI_ERR_EN
    logic multi_q, multi_d;

    // Flag a scan sample that shows more than one row low.
    always_comb begin
        multi_d = 1'b0;
        if (state_q == SCAN && cnt_q == SCAN_LAST && !one_low && rows_s != 4'hF) begin
            multi_d = 1'b1;
        end
    end

    // Register the multi-key flag so it is a clean one-cycle pulse.
    always_ff @(posedge clock) begin
        if (reset) begin
            multi_q <= 1'b0;
        end else begin
            multi_q <= multi_d;
        end
    end

    assign multi_key = multi_q;
`endif

    assign col_n      = ~(4'b0001 << col_idx_q);
    assign keyPressed = key_q;
    assign trig       = trig_q;
    assign key_strobe = strobe_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed testbench for keypad_scanner with SCAN_DIV=4, DEBOUNCE_CNT=8.
// A small keypad model pulls a row low only while the pressed key's
// column is being driven, like a real switch matrix.
module tb_keypad_scanner;

    logic       clock;
    logic       reset;
    logic [3:0] row_n;
    logic [3:0] col_n;
    logic [3:0] keyPressed;
    logic       trig;
    logic       key_strobe;
`ifdef KEYPAD_MULTI_ERR_EN
    logic       multi_key;
`endif

    logic       key_on, key2_on;
    logic [1:0] key_r, key_c, key2_r, key2_c;

    int n_compared;
    int n_mismatched;
    int strobe_seen;
    int multi_seen;

    typedef struct {
        int         cycles;
        logic       key_on;
        logic [1:0] r;
        logic [1:0] c;
        logic [3:0] exp_col;
        logic       exp_trig;
        logic [3:0] exp_key;
        logic       exp_strobe;
    } vec_t;

    vec_t vecs[15];

    keypad_scanner #(
        .SCAN_DIV     (4),
        .DEBOUNCE_CNT (8),
        .CNT_W        (8)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .row_n      (row_n),
        .col_n      (col_n),
        .keyPressed (keyPressed),
        .trig       (trig),
`ifdef KEYPAD_MULTI_ERR_EN
        .multi_key  (multi_key),
`endif
        .key_strobe (key_strobe)
    );

    // Free-running clock, 10 time units per cycle.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Keypad switch matrix: a pressed key shorts its row to its column.
    always_comb begin
        row_n = 4'hF;
        if (key_on && col_n[key_c] == 1'b0) row_n[key_r] = 1'b0;
        if (key2_on && col_n[key2_c] == 1'b0) row_n[key2_r] = 1'b0;
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        n_compared++;
        if (actual != expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        if (key_strobe) strobe_seen++;
`ifdef KEYPAD_MULTI_ERR_EN
        if (multi_key) multi_seen++;
`endif
    endtask

    task automatic applyStimulus(input vec_t v);
        key_on = v.key_on;
        key_r  = v.r;
        key_c  = v.c;
        repeat (v.cycles) tick();
    endtask

    task automatic waitCol(input logic [3:0] want, input string name);
        int n;
        n = 0;
        while (col_n != want && n < 40) begin
            tick();
            n++;
        end
        if (col_n != want) checkOutput(name, int'(col_n), int'(want));
    endtask

    task automatic waitTrig(input string name);
        int n;
        n = 0;
        while (trig != 1'b1 && n < 80) begin
            tick();
            n++;
        end
        if (trig != 1'b1) checkOutput(name, int'(trig), 1);
    endtask

    // Safety net so the run can never hang.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int trig_dropped;
        n_compared   = 0;
        n_mismatched = 0;
        strobe_seen  = 0;
        multi_seen   = 0;
        key2_on = 1'b0; key2_r = 2'd0; key2_c = 2'd0;

        // Rotation after reset, then a clean press/release of 'B' (r1, c3).
        vecs[0]  = '{1,  1'b0, 2'd0, 2'd0, 4'b1110, 1'b0, 4'd0,  1'b0};
        vecs[1]  = '{2,  1'b0, 2'd0, 2'd0, 4'b1110, 1'b0, 4'd0,  1'b0};
        vecs[2]  = '{1,  1'b0, 2'd0, 2'd0, 4'b1101, 1'b0, 4'd0,  1'b0};
        vecs[3]  = '{3,  1'b0, 2'd0, 2'd0, 4'b1101, 1'b0, 4'd0,  1'b0};
        vecs[4]  = '{1,  1'b0, 2'd0, 2'd0, 4'b1011, 1'b0, 4'd0,  1'b0};
        vecs[5]  = '{4,  1'b0, 2'd0, 2'd0, 4'b0111, 1'b0, 4'd0,  1'b0};
        vecs[6]  = '{4,  1'b0, 2'd0, 2'd0, 4'b1110, 1'b0, 4'd0,  1'b0};
        vecs[7]  = '{12, 1'b1, 2'd1, 2'd3, 4'b0111, 1'b0, 4'd0,  1'b0};
        vecs[8]  = '{4,  1'b1, 2'd1, 2'd3, 4'b0111, 1'b0, 4'd0,  1'b0};
        vecs[9]  = '{7,  1'b1, 2'd1, 2'd3, 4'b0111, 1'b0, 4'd0,  1'b0};
        vecs[10] = '{1,  1'b1, 2'd1, 2'd3, 4'b0111, 1'b1, 4'd11, 1'b1};
        vecs[11] = '{1,  1'b1, 2'd1, 2'd3, 4'b0111, 1'b1, 4'd11, 1'b0};
        vecs[12] = '{9,  1'b1, 2'd1, 2'd3, 4'b0111, 1'b1, 4'd11, 1'b0};
        vecs[13] = '{10, 1'b0, 2'd1, 2'd3, 4'b0111, 1'b1, 4'd11, 1'b0};
        vecs[14] = '{1,  1'b0, 2'd1, 2'd3, 4'b1110, 1'b0, 4'd11, 1'b0};

        // Reset held for 3 cycles with '5' pressed.
        reset  = 1'b1;
        key_on = 1'b1; key_r = 2'd1; key_c = 2'd1;
        repeat (3) tick();
        checkOutput("reset_col_n", int'(col_n), 4'b1110);
        checkOutput("reset_trig", int'(trig), 0);
        checkOutput("reset_keyPressed", int'(keyPressed), 0);
        checkOutput("reset_strobe", int'(key_strobe), 0);
        key_on = 1'b0;
        reset  = 1'b0;

        for (int i = 0; i < 15; i++) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("vec%0d_col_n", i), int'(col_n), int'(vecs[i].exp_col));
            checkOutput($sformatf("vec%0d_trig", i), int'(trig), int'(vecs[i].exp_trig));
            checkOutput($sformatf("vec%0d_keyPressed", i), int'(keyPressed), int'(vecs[i].exp_key));
            checkOutput($sformatf("vec%0d_strobe", i), int'(key_strobe), int'(vecs[i].exp_strobe));
        end

        // Bouncing press of '0' (r3, c1): low 3 cycles, high 1, then stable.
        key_on = 1'b1; key_r = 2'd3; key_c = 2'd1;
        waitCol(4'b1101, "bounce_wait_col1");
        strobe_seen = 0;
        repeat (3) tick();
        key_on = 1'b0;
        tick();
        key_on = 1'b1;
        repeat (2) tick();
        checkOutput("bounce_col_held", int'(col_n), 4'b1101);
        repeat (11) tick();
        checkOutput("bounce_trig_before", int'(trig), 0);
        checkOutput("bounce_no_early_strobe", strobe_seen, 0);
        tick();
        checkOutput("bounce_trig_rise", int'(trig), 1);
        checkOutput("bounce_strobe", int'(key_strobe), 1);
        checkOutput("bounce_keyPressed", int'(keyPressed), 0);
        tick();
        checkOutput("bounce_strobe_once", strobe_seen, 1);
        key_on = 1'b0;
        repeat (10) tick();
        checkOutput("bounce_release_trig_held", int'(trig), 1);
        tick();
        checkOutput("bounce_release_trig_fall", int'(trig), 0);

        // Release glitch while holding '7' (r2, c0).
        key_on = 1'b1; key_r = 2'd2; key_c = 2'd0;
        waitCol(4'b1110, "glitch_wait_col0");
        repeat (11) tick();
        checkOutput("glitch_trig_before", int'(trig), 0);
        tick();
        checkOutput("glitch_trig_rise", int'(trig), 1);
        checkOutput("glitch_keyPressed", int'(keyPressed), 7);
        repeat (3) tick();
        strobe_seen  = 0;
        trig_dropped = 0;
        key_on = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (!trig) trig_dropped++;
        end
        key_on = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (!trig) trig_dropped++;
        end
        checkOutput("glitch_trig_low_cycles", trig_dropped, 0);
        checkOutput("glitch_no_second_strobe", strobe_seen, 0);
        key_on = 1'b0;
        repeat (10) tick();
        checkOutput("glitch_release_trig_held", int'(trig), 1);
        tick();
        checkOutput("glitch_release_trig_fall", int'(trig), 0);

        // Two rows (r0 and r2) low on column 0: never accepted.
        key_on  = 1'b1; key_r  = 2'd0; key_c  = 2'd0;
        key2_on = 1'b1; key2_r = 2'd2; key2_c = 2'd0;
        waitCol(4'b1110, "multi_wait_col0");
        strobe_seen = 0;
        multi_seen  = 0;
        repeat (4) tick();
        checkOutput("multi_scan_advances", int'(col_n), 4'b1101);
`ifdef KEYPAD_MULTI_ERR_EN
        checkOutput("multi_key_pulse", int'(multi_key), 1);
        tick();
        checkOutput("multi_key_pulse_end", int'(multi_key), 0);
        repeat (11) tick();
        checkOutput("multi_key_count", multi_seen, 1);
`else
        repeat (12) tick();
`endif
        repeat (16) tick();
        checkOutput("multi_trig", int'(trig), 0);
        checkOutput("multi_no_strobe", strobe_seen, 0);
        key_on  = 1'b0;
        key2_on = 1'b0;

        // Reset while 'B' is held, then re-acceptance of the still-held key.
        key_on = 1'b1; key_r = 2'd1; key_c = 2'd3;
        waitTrig("held_wait_trig");
        repeat (2) tick();
        reset = 1'b1;
        tick();
        checkOutput("held_reset_trig", int'(trig), 0);
        checkOutput("held_reset_col_n", int'(col_n), 4'b1110);
        checkOutput("held_reset_keyPressed", int'(keyPressed), 0);
        reset = 1'b0;
        repeat (23) tick();
        checkOutput("reaccept_trig_before", int'(trig), 0);
        tick();
        checkOutput("reaccept_trig_rise", int'(trig), 1);
        checkOutput("reaccept_strobe", int'(key_strobe), 1);
        checkOutput("reaccept_keyPressed", int'(keyPressed), 11);
        key_on = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
